// File: rtl/bias_add_stage_pkg.sv
// Shared widths, saturation limits and lane-slice helper for the bias-add stage.
package bias_add_stage_pkg;
   localparam int DATA_W    = 18;
   localparam int SUM_W     = 19;
   localparam int MAX_LANES = 64;
   localparam int BUS_W     = MAX_LANES * DATA_W;

   localparam logic [DATA_W-1:0] SAT_MAX = 18'h1FFFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 18'h20000;

   // Callers cast their packed bus to BUS_W, so up to MAX_LANES lanes are addressable.
   function automatic logic [DATA_W-1:0] lane_slice(input logic [BUS_W-1:0] i_bus, input int i_lane);
      return i_bus[i_lane*DATA_W +: DATA_W];
   endfunction
endpackage

// File: rtl/bias_add_lane.sv
// One lane: 19-bit bias add (stage 1) and reduction to 18 bits (stage 2).
// BIAS_ADD_SAT_EN selects saturating reduction; otherwise the sum wraps.
module bias_add_lane
   import bias_add_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_adv,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_bias,
   output logic [DATA_W-1:0] o_data
);
   logic [SUM_W-1:0]  w_sum;
   logic [SUM_W-1:0]  r_sum;
   logic [DATA_W-1:0] w_red;
   logic [DATA_W-1:0] r_out;

   assign w_sum = {i_data[DATA_W-1], i_data} + {i_bias[DATA_W-1], i_bias};

   always_comb begin
`ifdef BIAS_ADD_SAT_EN
      // Top two bits disagree only when the sum left the 18-bit range.
      if (r_sum[SUM_W-1] != r_sum[SUM_W-2])
         w_red = r_sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
      else
         w_red = r_sum[DATA_W-1:0];
`else
      w_red = r_sum[DATA_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= '0;
         r_out <= '0;
      end else if (i_adv) begin
         r_sum <= w_sum;
         r_out <= w_red;
      end
   end

   assign o_data = r_out;
endmodule

// File: rtl/bias_add_stage.sv
// Two-stage per-lane bias add with valid/ready handshake and end-of-map flag.
// Optional BIAS_ADD_SAT_EN (in bias_add_lane) saturates instead of wrapping.
module bias_add_stage
   import bias_add_stage_pkg::*;
#(
   parameter int N_adder_tree = 16,
   parameter int PIX_PER_MAP  = 196
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_adder_tree*DATA_W-1:0] bias,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N_adder_tree*DATA_W-1:0] in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [N_adder_tree*DATA_W-1:0] out_data,
   output logic                           out_last
);
   localparam int STAGES = 2;
   localparam int CNT_W  = (PIX_PER_MAP > 1) ? $clog2(PIX_PER_MAP) : 1;

   logic              w_adv;
   logic              w_acc;
   logic              w_last;
   logic [STAGES:1]   r_vld_pipe;
   logic [STAGES:1]   r_last_pipe;
   logic [CNT_W-1:0]  r_pix_cnt;

   // Whole pipeline moves together whenever the output slot is free or being drained.
   assign w_adv    = out_ready | ~r_vld_pipe[STAGES];
   assign in_ready = w_adv;
   assign w_acc    = in_valid & w_adv;
   assign w_last   = (r_pix_cnt == CNT_W'(PIX_PER_MAP - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
         r_pix_cnt   <= '0;
      end else begin
         if (w_adv) begin
            r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], in_valid};
            r_last_pipe <= {r_last_pipe[STAGES-1:1], in_valid & w_last};
         end
         if (w_acc)
            r_pix_cnt <= w_last ? '0 : r_pix_cnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
      bias_add_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_adv  (w_adv),
         .i_data (lane_slice(BUS_W'(in_data), g)),
         .i_bias (lane_slice(BUS_W'(bias), g)),
         .o_data (out_data[g*DATA_W +: DATA_W])
      );
   end

   assign out_valid = r_vld_pipe[STAGES];
   assign out_last  = r_last_pipe[STAGES];
endmodule

// File: tb/tb_bias_add_stage.sv
// Directed bench for bias_add_stage: scoreboard of hand-modelled beats plus spot checks.
module tb_bias_add_stage;
   localparam int N   = 16;
   localparam int PPM = 4;
   localparam int DW  = 18;
   localparam int BW  = N * DW;

`ifdef BIAS_ADD_SAT_EN
   localparam logic [17:0] HAND_POS = 18'h1FFFF;
   localparam logic [17:0] HAND_NEG = 18'h20000;
`else
   localparam logic [17:0] HAND_POS = 18'h203A0;  // -130144
   localparam logic [17:0] HAND_NEG = 18'h1FC60;  //  130144
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] bias, in_data, out_data;
   logic          in_valid, in_ready, out_valid, out_ready, out_last;

   always #5 clk = ~clk;

   bias_add_stage #(.N_adder_tree(N), .PIX_PER_MAP(PPM)) dut (
      .clk(clk), .rst(rst), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [17:0] lane_of(input logic [BW-1:0] b, input int i);
      return b[i*DW +: DW];
   endfunction

   function automatic logic [17:0] model(input logic [17:0] a, input logic [17:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
`ifdef BIAS_ADD_SAT_EN
      if (s > 131071) s = 131071;
      else if (s < -131072) s = -131072;
`endif
      return s[17:0];
   endfunction

   function automatic logic [BW-1:0] mk_beat(input int seed);
      logic [BW-1:0] r;
      int v;
      for (int i = 0; i < N; i++) begin
         v = ((seed * 7919 + i * 1237) % 200000) - 100000;
         r[i*DW +: DW] = v[17:0];
      end
      return r;
   endfunction

   logic [BW:0]   exp_q[$];
   int            m_cnt;
   int            n_dlv;
   logic          prev_stall, prev_last, last_acc, dlv_now, last_dlv_last;
   logic [BW-1:0] prev_data;

   // One clock: drive at negedge, then score acceptance, delivery and stall stability.
   task automatic cycle(input logic v, input logic [BW-1:0] d, input logic r);
      logic [BW-1:0] e;
      logic [BW:0]   ent;
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = r;
      #1;
      if (prev_stall) begin
         chk("stall_valid", out_valid, 1);
         for (int i = 0; i < N; i++)
            chk($sformatf("stall_data[%0d]", i), lane_of(out_data, i), lane_of(prev_data, i));
         chk("stall_last", out_last, prev_last);
      end
      last_acc = v && in_ready;
      if (last_acc) begin
         for (int i = 0; i < N; i++) e[i*DW +: DW] = model(lane_of(d, i), lane_of(bias, i));
         exp_q.push_back({(m_cnt == PPM - 1), e});
         m_cnt = (m_cnt == PPM - 1) ? 0 : m_cnt + 1;
      end
      dlv_now = out_valid && r;
      if (dlv_now) begin
         n_dlv++;
         last_dlv_last = out_last;
         if (exp_q.size() == 0) chk("spurious_beat", out_valid, 0);
         else begin
            ent = exp_q.pop_front();
            for (int i = 0; i < N; i++)
               chk($sformatf("dlv_data[%0d]", i), lane_of(out_data, i), lane_of(ent[BW-1:0], i));
            chk("dlv_last", out_last, ent[BW]);
         end
      end
      prev_stall = out_valid && !r;
      prev_data  = out_data;
      prev_last  = out_last;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      prev_stall = 1'b0;
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [BW-1:0] beat;
      logic [8:0]    lmask;
      logic [11:0]   ivh, ovh;
      int            sent, cyc, t;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      m_cnt = 0; n_dlv = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      last_acc = 1'b0; dlv_now = 1'b0; last_dlv_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         t = (i == 0) ? -50 : (i == 1) ? 1000 : (i == 2) ? -1000 : i * 500 - 4000;
         bias[i*DW +: DW] = t[17:0];
      end

      // Reset state
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", |out_data, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pix_cnt", dut.r_pix_cnt, 0);

      // Basic add and two-cycle latency
      beat = mk_beat(1);
      beat[17:0] = 18'd100;
      cycle(1'b1, beat, 1'b1);
      chk("lat_accept", last_acc, 1);
      cycle(1'b0, '0, 1'b1);
      chk("lat_c1_valid", out_valid, 0);
      cycle(1'b0, '0, 1'b1);
      chk("lat_c2_valid", out_valid, 1);
      chk("basic_lane0", lane_of(out_data, 0), 18'd50);

      // Overflow on both rails
      beat = mk_beat(2);
      t = 131000;  beat[1*DW +: DW] = t[17:0];
      t = -131000; beat[2*DW +: DW] = t[17:0];
      cycle(1'b1, beat, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      chk("ovf_valid", out_valid, 1);
      chk("ovf_pos", lane_of(out_data, 1), HAND_POS);
      chk("ovf_neg", lane_of(out_data, 2), HAND_NEG);

      // Backpressure: out_ready 1,0,0,1 repeating
      n_dlv = 0; sent = 0; cyc = 0;
      while (n_dlv < 10 && cyc < 100) begin
         cycle(sent < 10, mk_beat(10 + sent), (cyc % 4 == 0) || (cyc % 4 == 3));
         if (last_acc) sent++;
         cyc++;
      end
      chk("bp_delivered", n_dlv, 10);
      chk("bp_queue_empty", exp_q.size(), 0);

      // Last flag over 9 beats with gaps
      do_reset();
      n_dlv = 0; sent = 0; cyc = 0; lmask = '0;
      while ((sent < 9 || n_dlv < 9) && cyc < 100) begin
         cycle((sent < 9) && ((cyc * 5) % 7 < 4), mk_beat(20 + sent), 1'b1);
         if (last_acc) sent++;
         if (dlv_now && n_dlv <= 9) lmask[n_dlv-1] = last_dlv_last;
         cyc++;
      end
      chk("last_delivered", n_dlv, 9);
      chk("last_mask", lmask, 9'b010001000);
      chk("pix_cnt_after", dut.r_pix_cnt, 1);

      // Bubbles: every other cycle
      do_reset();
      ivh = '0; ovh = '0;
      for (int k = 0; k < 12; k++) begin
         cycle((k < 8) && (k % 2 == 0), mk_beat(40 + k), 1'b1);
         ivh[k] = in_valid;
         ovh[k] = out_valid;
      end
      chk("bubble_pattern", ovh, ivh << 2);

      // Reset while full and stalled
      cycle(1'b1, mk_beat(60), 1'b0);
      cycle(1'b1, mk_beat(61), 1'b0);
      cycle(1'b1, mk_beat(62), 1'b0);
      chk("full_out_valid", out_valid, 1);
      chk("full_in_ready", in_ready, 0);
      do_reset();
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_pix_cnt", dut.r_pix_cnt, 0);
      n_dlv = 0;
      repeat (6) cycle(1'b0, '0, 1'b1);
      chk("post_rst_no_beats", n_dlv, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
